// File: rtl/mips_run_ctrl.sv
// Run/step sequencer for the pipelined MIPS core: produces the global pipeline
// advance enable, the clear pulse to the pipeline and an enabled-cycle count.
module mips_run_ctrl #(
   parameter int unsigned len_data     = 32,
   parameter int unsigned clear_cycles = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   input  logic [1:0]          cmd_code,
   output logic                cmd_ready,
   input  logic                halt_flag_wb,
   output logic                ctrl_clk_mips,
   output logic                mips_reset,
   output logic [len_data-1:0] cycle_count,
   output logic                step_done,
   output logic                done,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_STEP   = 3'd2,
      S_PAUSED = 3'd3,
      S_DONE   = 3'd4,
      S_CLEAR  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      C_RUN   = 2'b00,
      C_STEP  = 2'b01,
      C_STOP  = 2'b10,
      C_CLEAR = 2'b11
   } cmd_t;

   state_t              state_q, state_d;
   logic [3:0]          clr_cnt_q, clr_cnt_d;
   logic [len_data-1:0] count_q, count_d;
   logic                run_en_q, ready_q, mreset_q, step_done_q, done_q;
   logic                accept, enter_clear;
   cmd_t                cmd;

   assign cmd    = cmd_t'(cmd_code);
   assign accept = cmd_valid && ready_q;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      count_d     = count_q;
      enter_clear = 1'b0;

      if (run_en_q && (count_q != '1))
         count_d = count_q + len_data'(1);

      unique case (state_q)
         S_IDLE, S_PAUSED: begin
            if (accept) begin
               unique case (cmd)
                  C_RUN:   state_d = S_RUN;
                  C_STEP:  state_d = S_STEP;
                  C_CLEAR: enter_clear = 1'b1;
                  default: ;
               endcase
            end
         end
         // CLEAR beats halt, halt beats STOP
         S_RUN: begin
            if (accept && (cmd == C_CLEAR))
               enter_clear = 1'b1;
            else if (halt_flag_wb)
               state_d = S_DONE;
            else if (accept && (cmd == C_STOP))
               state_d = S_PAUSED;
         end
         S_STEP:
            state_d = halt_flag_wb ? S_DONE : S_PAUSED;
         S_DONE: begin
            if (accept && (cmd == C_CLEAR))
               enter_clear = 1'b1;
         end
         S_CLEAR: begin
            if (clr_cnt_q == 4'd0)
               state_d = S_IDLE;
            else
               clr_cnt_d = clr_cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase

      if (enter_clear) begin
         state_d   = S_CLEAR;
         clr_cnt_d = 4'(clear_cycles - 1);
         count_d   = '0;
      end
   end

   // Outputs are registered from the next state so they stay exact decodes of state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         clr_cnt_q   <= '0;
         count_q     <= '0;
         run_en_q    <= 1'b0;
         ready_q     <= 1'b1;
         mreset_q    <= 1'b0;
         step_done_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         count_q     <= count_d;
         run_en_q    <= (state_d == S_RUN) || (state_d == S_STEP);
         ready_q     <= !((state_d == S_STEP) || (state_d == S_CLEAR));
         mreset_q    <= (state_d == S_CLEAR);
         step_done_q <= (state_q == S_STEP);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign state         = state_q;
   assign ctrl_clk_mips = run_en_q;
   assign cmd_ready     = ready_q;
   assign mips_reset    = mreset_q;
   assign cycle_count   = count_q;
   assign step_done     = step_done_q;
   assign done          = done_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances (32-bit count / 2 clear cycles and
// 4-bit count / 3 clear cycles) checked every cycle against a behavioural model.
module tb_mips_run_ctrl;

   localparam int RUN = 0, STEP = 1, STOP = 2, CLR = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, cmd_valid, halt;
   logic [1:0] cmd_code;

   logic        ready_o [2];
   logic        en_o    [2];
   logic        mrst_o  [2];
   logic        sd_o    [2];
   logic        done_o  [2];
   logic [2:0]  st_o    [2];
   logic [31:0] cnt0;
   logic [3:0]  cnt1;
   longint unsigned cnt_o [2];

   assign cnt_o[0] = 64'(cnt0);
   assign cnt_o[1] = 64'(cnt1);

   mips_run_ctrl #(.len_data(32), .clear_cycles(2)) u0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_ready(ready_o[0]), .halt_flag_wb(halt), .ctrl_clk_mips(en_o[0]),
      .mips_reset(mrst_o[0]), .cycle_count(cnt0), .step_done(sd_o[0]),
      .done(done_o[0]), .state(st_o[0]));

   mips_run_ctrl #(.len_data(4), .clear_cycles(3)) u1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_ready(ready_o[1]), .halt_flag_wb(halt), .ctrl_clk_mips(en_o[1]),
      .mips_reset(mrst_o[1]), .cycle_count(cnt1), .step_done(sd_o[1]),
      .done(done_o[1]), .state(st_o[1]));

   int unsigned total = 0, bad = 0;

   task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Model: state number, count, clear cycles still to go, pending step_done.
   int              m_st  [2];
   longint unsigned m_cnt [2];
   int              m_rem [2];
   bit              m_sd  [2];
   longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'd15};
   int              m_cc  [2] = '{2, 3};

   function automatic bit m_en(int i);
      return (m_st[i] == 1) || (m_st[i] == 2);
   endfunction

   function automatic bit m_ready(int i);
      return !((m_st[i] == 2) || (m_st[i] == 5));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_cnt[i] = 0; m_rem[i] = 0; m_sd[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit acc, go_clear;
         acc      = cmd_valid && m_ready(i);
         go_clear = 0;
         m_sd[i]  = (m_st[i] == 2);
         if (m_en(i) && m_cnt[i] < m_max[i]) m_cnt[i]++;
         case (m_st[i])
            0, 3: if (acc) begin
               if (cmd_code == RUN)       m_st[i] = 1;
               else if (cmd_code == STEP) m_st[i] = 2;
               else if (cmd_code == CLR)  go_clear = 1;
            end
            1: begin
               if (acc && cmd_code == CLR) go_clear = 1;
               else if (halt)              m_st[i] = 4;
               else if (acc && cmd_code == STOP) m_st[i] = 3;
            end
            2: m_st[i] = halt ? 4 : 3;
            4: if (acc && cmd_code == CLR) go_clear = 1;
            5: begin
               m_rem[i]--;
               if (m_rem[i] == 0) m_st[i] = 0;
            end
            default: ;
         endcase
         if (go_clear) begin
            m_st[i] = 5; m_rem[i] = m_cc[i]; m_cnt[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("u%0d.state", i),     64'(st_o[i]),   64'(m_st[i]));
         check_val($sformatf("u%0d.enable", i),    64'(en_o[i]),   64'(m_en(i)));
         check_val($sformatf("u%0d.ready", i),     64'(ready_o[i]), 64'(m_ready(i)));
         check_val($sformatf("u%0d.mips_reset", i), 64'(mrst_o[i]), 64'(m_st[i] == 5));
         check_val($sformatf("u%0d.done", i),      64'(done_o[i]), 64'(m_st[i] == 4));
         check_val($sformatf("u%0d.step_done", i), 64'(sd_o[i]),   64'(m_sd[i]));
         check_val($sformatf("u%0d.count", i),     cnt_o[i],       m_cnt[i]);
      end
   endtask

   // One cycle: check current outputs, present inputs, advance the model.
   task automatic cyc(input bit v, input int c, input bit h, input bit r);
      check_all();
      reset = r; cmd_valid = v; cmd_code = 2'(c); halt = h;
      if (r) model_reset(); else model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
   endtask

   task automatic clear_to_idle();
      cyc(1, CLR, 0, 0);
      idle(5);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_code = 2'b00; halt = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);

      // Run until halt sampled at count 9
      cyc(1, RUN, 0, 0);
      for (int k = 0; k < 100 && m_cnt[0] != 9; k++) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      idle(2);
      check_val("halt_count", cnt_o[0], 10);
      check_val("halt_done", 64'(done_o[0]), 1);
      check_val("halt_enable", 64'(en_o[0]), 0);

      // CLEAR from DONE, then three single steps
      clear_to_idle();
      check_val("clear_count", cnt_o[0], 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1, STEP, 0, 0);
         idle(2);
      end
      check_val("step_count", cnt_o[0], 3);
      check_val("step_state", 64'(st_o[0]), 3);

      // RUN 5, STOP, RUN 4 more
      clear_to_idle();
      cyc(1, RUN, 0, 0);
      for (int k = 0; k < 100 && m_cnt[0] != 4; k++) cyc(0, 0, 0, 0);
      cyc(1, STOP, 0, 0);
      idle(2);
      cyc(1, RUN, 0, 0);
      for (int k = 0; k < 100 && m_cnt[0] != 8; k++) cyc(0, 0, 0, 0);
      cyc(1, STOP, 0, 0);
      idle(1);
      check_val("stop_count", cnt_o[0], 9);

      // Same-edge STOP+halt, then same-edge CLEAR+halt
      clear_to_idle();
      cyc(1, RUN, 0, 0);
      idle(2);
      cyc(1, STOP, 1, 0);
      check_val("stop_halt_state", 64'(st_o[0]), 4);
      clear_to_idle();
      cyc(1, RUN, 0, 0);
      idle(2);
      cyc(1, CLR, 1, 0);
      check_val("clear_halt_state", 64'(st_o[0]), 5);
      idle(5);

      // Saturation of the 4-bit counter, then reset mid-RUN
      cyc(1, RUN, 0, 0);
      idle(20);
      check_val("sat_count", cnt_o[1], 15);
      cyc(0, 0, 0, 1);
      idle(1);

      // Random commands, halts and occasional resets
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(1, 0) == 1), int'($urandom_range(3, 0)),
             ($urandom_range(7, 0) == 0), ($urandom_range(99, 0) == 0));
      end
      check_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run/step sequencer for the pipelined MIPS core. Generates the global pipeline enable `ctrl_clk_mips`, which gates every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It accepts commands from the debug/UART front-end to run continuously, single-step, pause, or clear the core. It stops the core when the halt marker reaches write-back and keeps an enabled-cycle count for readback.

## Interface
- `len_data`, 32: width of the cycle counter.
- `clear_cycles`, 2: number of cycles `mips_reset` is held during CLEAR; legal range 1..15.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_code` in 2: 00 RUN, 01 STEP, 10 STOP, 11 CLEAR.
- `cmd_ready` out 1: the command is accepted at an edge where `cmd_valid && cmd_ready`.
- `halt_flag_wb` in 1: halt marker has reached write-back; sampled only when `ctrl_clk_mips`=1.
- `ctrl_clk_mips` out 1: pipeline advance enable.
- `mips_reset` out 1: reset pulse to the pipeline latches, PC and register file.
- `cycle_count` out `len_data`: number of enabled cycles since the last CLEAR or `reset`.
- `step_done` out 1: one-cycle pulse after a completed STEP.
- `done` out 1: core halted; high while in DONE.
- `state` out 3: IDLE=0, RUN=1, STEP=2, PAUSED=3, DONE=4, CLEAR=5.

## Operation
- Reset values: state IDLE, `ctrl_clk_mips`=0, `mips_reset`=0, `cycle_count`=0, `step_done`=0, `done`=0, `cmd_ready`=1.
- `reset` has priority over everything, including a command presented in the same cycle.
- `ctrl_clk_mips` = (state==RUN) | (state==STEP). It is a decode of the state register, so it is glitch-free.
- `cmd_ready` = 1 in IDLE, RUN, PAUSED and DONE; 0 in STEP and CLEAR.
- IDLE and PAUSED:
  - RUN → RUN; STEP → STEP; CLEAR → CLEAR.
  - STOP is accepted and ignored.
- RUN:
  - STOP → PAUSED; CLEAR → CLEAR (abort).
  - RUN and STEP are accepted and ignored.
  - `halt_flag_wb`=1 at an edge → DONE. Halt takes priority over a simultaneous STOP, but a simultaneous CLEAR wins over both.
- STEP:
  - Lasts exactly one cycle, then → PAUSED with `step_done`=1 in the first PAUSED cycle.
  - If `halt_flag_wb`=1 at that edge → DONE instead; `step_done` still pulses.
- DONE:
  - `done`=1 and the enable stays low.
  - Only CLEAR has effect (→ CLEAR); other commands are accepted and ignored.
  - `halt_flag_wb` is ignored.
- CLEAR:
  - `mips_reset`=1 for exactly `clear_cycles` cycles; `cycle_count` is zeroed on entry; `done` is cleared.
  - Then → IDLE.
  - An internal down-counter (4 bits) loads `clear_cycles`-1 on entry.
- `cycle_count`:
  - +1 at every edge where `ctrl_clk_mips`=1.
  - Saturates at 2^`len_data`-1; no wrap.

## Timing
- Command accepted at edge N → new state at N+1. `ctrl_clk_mips` is high in cycle N+1 for RUN/STEP.
- STEP: exactly one enabled cycle per command. `step_done` is high in the following cycle. The earliest next command is accepted one cycle after STEP ends.
- Halt: the cycle in which `halt_flag_wb` is sampled high is enabled and counted. `ctrl_clk_mips`=0 and `done`=1 from the next cycle.
- STOP in RUN at edge N: the last enabled cycle is the one ending at N.
- CLEAR accepted at edge N: `mips_reset` is high for cycles N+1 through N+`clear_cycles`. State is IDLE at N+`clear_cycles`+1, with `cmd_ready`=1 that cycle.
- `reset` mid-RUN or mid-CLEAR: all outputs return to reset values at the next edge.
  - `mips_reset` is deasserted by it; the top level ORs `reset` into the pipeline reset.

## Test plan
- RUN accepted at cycle 0, `halt_flag_wb` forced high when `cycle_count`=9 → 10 enabled cycles, `cycle_count`=10, `done`=1, `ctrl_clk_mips`=0 thereafter.
- STEP issued 3 times (each once `cmd_ready`=1) → 3 single-cycle enable pulses, 3 `step_done` pulses, `cycle_count`=3, final state PAUSED.
- RUN, then STOP after 5 enabled cycles, then RUN again for 4 more cycles → `cycle_count`=9, PAUSED between runs with enable low.
- CLEAR with `clear_cycles`=2 from DONE → `mips_reset` high exactly 2 cycles, `cycle_count`=0, `done`=0, IDLE on the 3rd cycle.
- Same-edge STOP and `halt_flag_wb`=1 in RUN → DONE. Same-edge CLEAR and halt → CLEAR.
- `len_data`=4, RUN with no halt for 20 cycles → `cycle_count` saturates at 15. `reset` asserted mid-RUN → all outputs return to reset values at the next edge.
